// File: rtl/frame_center_snapshot.sv
`timescale 1ns/1ps
// Once per video frame: capture sprite world locations, convert them to pixel
// centres one sprite per cycle, then commit every sprite to the display at once.
module frame_center_snapshot #(
    parameter int SPRITES    = 2,
    parameter int DIMENSIONS = 2,
    parameter int WIDTH      = 32,
    parameter int SHIFT      = 18,
    parameter int H_ACTIVE   = 1600,
    parameter int V_ACTIVE   = 1200
) (
    input  logic                                            clock_162,
    input  logic                                            rst,
    input  logic                                            frame_start,
    input  logic                                            loc_valid,
    input  logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0]   locations,
    output logic [SPRITES-1:0][10:0]                        sprite_row,
    output logic [SPRITES-1:0][11:0]                        sprite_col,
    output logic [SPRITES-1:0]                              oob,
    output logic                                            snapshot_valid,
    output logic                                            busy,
    output logic [7:0]                                      missed_frames
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_LOC = 2'd1;
    localparam logic [1:0] CONVERT  = 2'd2;
    localparam logic [1:0] COMMIT   = 2'd3;

    localparam int IDX_W = (SPRITES > 1) ? $clog2(SPRITES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SPRITES - 1);

    typedef logic signed [WIDTH:0] wide_t;

    localparam wide_t COL_MID = wide_t'(H_ACTIVE / 2);
    localparam wide_t COL_MAX = wide_t'(H_ACTIVE - 1);
    localparam wide_t ROW_MID = wide_t'(V_ACTIVE / 2);
    localparam wide_t ROW_MAX = wide_t'(V_ACTIVE - 1);
    localparam logic [11:0] COL_RST = 12'(H_ACTIVE / 2);
    localparam logic [10:0] ROW_RST = 11'(V_ACTIVE / 2);

    function automatic wide_t clamp_axis(input wide_t v, input wide_t hi);
        if (v < 0)
            return '0;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

    function automatic logic is_clamped(input wide_t v, input wide_t hi);
        return (v < 0) || (v > hi);
    endfunction

    logic [1:0]                                     state;
    logic [IDX_W-1:0]                               idx;
    logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0]  loc_p0;
    logic [SPRITES-1:0][11:0]                       stage_col_p1;
    logic [SPRITES-1:0][10:0]                       stage_row_p1;
    logic [SPRITES-1:0]                             stage_oob_p1;

    logic signed [WIDTH-1:0] cur_x;
    logic signed [WIDTH-1:0] cur_y;
    wide_t sx, sy, col_raw, row_raw, col_sat, row_sat;
    logic  col_clip, row_clip;
    logic  unused_loc;

    // Conversion of the sprite selected by idx from the captured shadow copy
    assign cur_x   = loc_p0[idx][0];
    assign cur_y   = loc_p0[idx][1];
    assign sx      = wide_t'(cur_x) >>> SHIFT;
    assign sy      = wide_t'(cur_y) >>> SHIFT;
    assign col_raw = COL_MID + sx;
    assign row_raw = ROW_MID - sy;
    assign col_sat = clamp_axis(col_raw, COL_MAX);
    assign row_sat = clamp_axis(row_raw, ROW_MAX);
    assign col_clip = is_clamped(col_raw, COL_MAX);
    assign row_clip = is_clamped(row_raw, ROW_MAX);
    assign unused_loc = ^loc_p0;

    assign busy = (state != IDLE);

    always_ff @(posedge clock_162 or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            loc_p0         <= '0;
            stage_col_p1   <= '0;
            stage_row_p1   <= '0;
            stage_oob_p1   <= '0;
            oob            <= '0;
            snapshot_valid <= 1'b0;
            missed_frames  <= 8'd0;
            for (int i = 0; i < SPRITES; i++) begin
                sprite_col[i] <= COL_RST;
                sprite_row[i] <= ROW_RST;
            end
        end else begin
            snapshot_valid <= 1'b0;
            if (frame_start && (state != IDLE) && (missed_frames != 8'hFF))
                missed_frames <= missed_frames + 8'd1;

            case (state)
                IDLE: begin
                    if (frame_start)
                        state <= WAIT_LOC;
                end
                // Capture boundary: shadow the whole bus so later changes are ignored
                WAIT_LOC: begin
                    if (loc_valid) begin
                        loc_p0 <= locations;
                        idx    <= '0;
                        state  <= CONVERT;
                    end
                end
                // Staging boundary: one sprite's clamped centre per cycle
                CONVERT: begin
                    stage_col_p1[idx] <= col_sat[11:0];
                    stage_row_p1[idx] <= row_sat[10:0];
                    stage_oob_p1[idx] <= col_clip | row_clip;
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= COMMIT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                // Output boundary: all sprites change together
                COMMIT: begin
                    sprite_col     <= stage_col_p1;
                    sprite_row     <= stage_row_p1;
                    oob            <= stage_oob_p1;
                    snapshot_valid <= 1'b1;
                    idx            <= '0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_center_snapshot.sv
`timescale 1ns/1ps
// Directed + randomized bench for frame_center_snapshot with a behavioural
// model of the coordinate-to-pixel conversion.
module tb_frame_center_snapshot;

    localparam int SPR = 2;
    localparam int DIM = 2;
    localparam int W   = 32;

    typedef logic [SPR-1:0][DIM-1:0][W-1:0] loc_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   frame_start;
    logic                   loc_valid;
    loc_t                   locations;
    logic [SPR-1:0][10:0]   sprite_row;
    logic [SPR-1:0][11:0]   sprite_col;
    logic [SPR-1:0]         oob;
    logic                   snapshot_valid;
    logic                   busy;
    logic [7:0]             missed_frames;

    int checks   = 0;
    int failures = 0;
    int exp_col [SPR];
    int exp_row [SPR];
    int exp_oob [SPR];
    int exp_missed = 0;

    frame_center_snapshot #(
        .SPRITES(SPR), .DIMENSIONS(DIM), .WIDTH(W), .SHIFT(18),
        .H_ACTIVE(1600), .V_ACTIVE(1200)
    ) dut (
        .clock_162      (clk),
        .rst            (rst),
        .frame_start    (frame_start),
        .loc_valid      (loc_valid),
        .locations      (locations),
        .sprite_row     (sprite_row),
        .sprite_col     (sprite_col),
        .oob            (oob),
        .snapshot_valid (snapshot_valid),
        .busy           (busy),
        .missed_frames  (missed_frames)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Screen centre plus world offset in pixels (1.0 world = 64 px), y up, clipped to the screen.
    task automatic model(input loc_t l);
        for (int i = 0; i < SPR; i++) begin
            longint xv, yv, c, r;
            xv = longint'($signed(l[i][0]));
            yv = longint'($signed(l[i][1]));
            c = 800 + (xv >>> 18);
            r = 600 - (yv >>> 18);
            exp_oob[i] = (c < 0 || c > 1599 || r < 0 || r > 1199) ? 1 : 0;
            exp_col[i] = (c < 0) ? 0 : (c > 1599) ? 1599 : int'(c);
            exp_row[i] = (r < 0) ? 0 : (r > 1199) ? 1199 : int'(r);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SPR; i++) begin
            exp_col[i] = 800;
            exp_row[i] = 600;
            exp_oob[i] = 0;
        end
        exp_missed = 0;
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < SPR; i++) begin
            chk($sformatf("%s_col%0d", tag, i), sprite_col[i], exp_col[i]);
            chk($sformatf("%s_row%0d", tag, i), sprite_row[i], exp_row[i]);
            chk($sformatf("%s_oob%0d", tag, i), oob[i], exp_oob[i]);
        end
    endtask

    function automatic logic [31:0] rnd_coord();
        logic [31:0] r;
        r = $urandom;
        if (r[0])
            r = $signed(r) >>> 5;
        return r;
    endfunction

    function automatic loc_t rnd_loc();
        loc_t l;
        for (int i = 0; i < SPR; i++)
            for (int d = 0; d < DIM; d++)
                l[i][d] = rnd_coord();
        return l;
    endfunction

    // Entered at a negedge; pulses frame_start with loc_valid already high.
    task automatic do_frame(input string tag, input loc_t loc, input bit alt,
                            input loc_t loc_alt, input bit pulse_in_commit);
        int k;
        int hold_col;
        hold_col = exp_col[0];
        locations   = loc;
        loc_valid   = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        k = 1;
        while (!snapshot_valid && k < 20) begin
            if (alt && k == 2)
                locations = loc_alt;
            if (k == 4)
                chk({tag, "_hold"}, sprite_col[0], hold_col);
            frame_start = (pulse_in_commit && k == 4);
            @(negedge clk);
            k++;
        end
        frame_start = 1'b0;
        chk({tag, "_latency"}, k, 5);
        model(loc);
        if (pulse_in_commit && exp_missed < 255)
            exp_missed++;
        check_outputs(tag);
        @(negedge clk);
        chk({tag, "_vld_one_cycle"}, snapshot_valid, 0);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_missed"}, missed_frames, exp_missed);
    endtask

    initial begin
        loc_t l, l2;
        int k;
        int seen;

        rst = 1'b1;
        frame_start = 1'b0;
        loc_valid = 1'b0;
        locations = '0;
        locations[0][0] = 32'h0100_0000;
        locations[0][1] = 32'h0100_0000;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_outputs("reset");
        chk("reset_busy", busy, 0);
        chk("reset_vld", snapshot_valid, 0);
        chk("reset_missed", missed_frames, 0);

        // Directed conversion, ±1.0 world units
        l = '0;
        l[0][0] = 32'h0100_0000; l[0][1] = 32'h0100_0000;
        l[1][0] = 32'hff00_0000; l[1][1] = 32'hff00_0000;
        do_frame("basic", l, 1'b0, l, 1'b0);
        chk("basic_c0_abs", sprite_col[0], 864);
        chk("basic_r1_abs", sprite_row[1], 664);

        // Extreme coordinates clamp; sprite at origin sits at screen centre
        l = '0;
        l[0][0] = 32'h7fff_ffff; l[0][1] = 32'h8000_0000;
        do_frame("clamp", l, 1'b0, l, 1'b0);
        chk("clamp_c0_abs", sprite_col[0], 1599);
        chk("clamp_r0_abs", sprite_row[0], 1199);
        chk("clamp_oob_abs", oob, 2'b01);

        for (int n = 0; n < 6; n++)
            do_frame($sformatf("rand%0d", n), rnd_loc(), 1'b0, l, 1'b0);

        // frame_start landing on the COMMIT cycle is ignored but counted
        do_frame("commit_pulse", rnd_loc(), 1'b0, l, 1'b1);

        // Locations change right after capture
        l  = rnd_loc();
        l2 = rnd_loc();
        do_frame("late_change", l, 1'b1, l2, 1'b0);

        // loc_valid held low: stay busy, count a second frame_start
        locations = rnd_loc();
        loc_valid = 1'b0;
        frame_start = 1'b1;
        @(negedge clk);
        for (int c = 1; c < 50; c++) begin
            frame_start = (c == 20);
            @(negedge clk);
        end
        frame_start = 1'b0;
        exp_missed++;
        chk("wait_busy", busy, 1);
        chk("wait_missed", missed_frames, exp_missed);
        check_outputs("wait_hold");

        // Saturation of the missed-frame counter
        for (int c = 0; c < 300; c++) begin
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
            @(negedge clk);
        end
        exp_missed = 255;
        chk("missed_sat", missed_frames, 255);
        chk("sat_vld", snapshot_valid, 0);

        l = rnd_loc();
        locations = l;
        loc_valid = 1'b1;
        k = 0;
        while (!snapshot_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("late_valid_latency", k, 4);
        model(l);
        check_outputs("late_valid");
        chk("late_valid_missed", missed_frames, 255);
        @(negedge clk);
        chk("late_valid_idle", busy, 0);

        // Reset during CONVERT after committing col 864
        l = '0;
        l[0][0] = 32'h0100_0000; l[0][1] = 32'h0100_0000;
        l[1][0] = 32'hff00_0000; l[1][1] = 32'hff00_0000;
        do_frame("pre_reset", l, 1'b0, l, 1'b0);
        locations = rnd_loc();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("conv_busy", busy, 1);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        chk("async_rst_busy", busy, 0);
        chk("async_rst_missed", missed_frames, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (snapshot_valid)
                seen++;
        end
        chk("no_commit_after_rst", seen, 0);
        check_outputs("post_rst");
        chk("post_rst_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
